// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, pattern mode encodings and colour-bar table.
package vga_timing_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  localparam int unsigned NumBars = 8;

  typedef enum logic [1:0] {
    ModeBands   = 2'd0,
    ModeBars    = 2'd1,
    ModeChecker = 2'd2,
    ModeBlack   = 2'd3
  } vga_mode_e;

  // Returns {R,G,B}; index NumBars and above is the black remainder region.
  function automatic logic [2:0] bar_rgb(input logic [3:0] idx);
    case (idx)
      4'd0:    bar_rgb = 3'b111;
      4'd1:    bar_rgb = 3'b110;
      4'd2:    bar_rgb = 3'b011;
      4'd3:    bar_rgb = 3'b010;
      4'd4:    bar_rgb = 3'b101;
      4'd5:    bar_rgb = 3'b100;
      4'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable plus sync and active-region decode.
module vga_axis_counter #(
  parameter int unsigned W      = 10,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_last,
  output logic         o_sync,
  output logic         o_active
);

  localparam int unsigned Total = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LastCnt   = W'(Total - 1);
  localparam logic [W-1:0] SyncStart = W'(ACTIVE + FP);
  localparam logic [W-1:0] SyncEnd   = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] ActEnd    = W'(ACTIVE);

  logic [W-1:0] r_count;
  logic         w_in_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_last ? '0 : r_count + 1'b1;
    end
  end

  assign w_in_sync = (r_count >= SyncStart) && (r_count <= SyncEnd);
  assign o_count   = r_count;
  assign o_last    = (r_count == LastCnt);
  assign o_sync    = w_in_sync ? POL : ~POL;
  assign o_active  = (r_count < ActEnd);

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster controller: H/V timing, frame markers, band/bar/checker pixel source and
// a two-stage output pipeline keeping sync, blank and RGB mutually aligned.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned H_FP        = DefHFp,
  parameter int unsigned H_SYNC      = DefHSync,
  parameter int unsigned H_BP        = DefHBp,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned V_FP        = DefVFp,
  parameter int unsigned V_SYNC      = DefVSync,
  parameter int unsigned V_BP        = DefVBp,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned XW          = 10,
  parameter int unsigned COLOUR_BITS = 8,
  parameter int unsigned BANDS       = 2,
  parameter int unsigned BAND_WIDTH  = 64,
  parameter int unsigned CHK_LOG2    = 4
) (
  input  logic                   vga_clock,
  input  logic                   reset,
  input  logic [3*BANDS-1:0]     colour,
  input  logic [1:0]             mode,
  output logic [XW-1:0]          x,
  output logic [XW-1:0]          y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [15:0]            frame_count,
  output logic [COLOUR_BITS-1:0] VGA_R,
  output logic [COLOUR_BITS-1:0] VGA_G,
  output logic [COLOUR_BITS-1:0] VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK,
  output logic                   VGA_SYNC,
  output logic                   VGA_CLK
);

  localparam int unsigned BandW = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam logic [BandW-1:0] BandLast    = BandW'(BANDS - 1);
  localparam logic [XW-1:0]    BandSubLast = XW'(BAND_WIDTH - 1);
  localparam logic [XW-1:0]    BarSubLast  = XW'(H_ACTIVE / NumBars - 1);
  localparam logic [3:0]       BarBlack    = 4'(NumBars);

  logic [XW-1:0]    w_x, w_y;
  logic             w_h_last, w_v_last, w_hs, w_vs, w_h_act, w_v_act, w_visible;
  vga_mode_e        r_mode, w_mode;
  logic [BandW-1:0] r_band;
  logic [XW-1:0]    r_band_sub, r_bar_sub;
  logic [3:0]       r_bar;
  logic [2:0]       w_rgb;
  logic             r_hs1, r_vs1, r_blank1, r_hs2, r_vs2, r_blank2;
  logic [2:0]       r_rgb1, r_rgb2;
  logic [15:0]      r_frame_count;

  vga_axis_counter #(
    .W(XW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h (
    .i_clk(vga_clock), .i_reset(reset), .i_en(1'b1),
    .o_count(w_x), .o_last(w_h_last), .o_sync(w_hs), .o_active(w_h_act)
  );

  vga_axis_counter #(
    .W(XW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v (
    .i_clk(vga_clock), .i_reset(reset), .i_en(w_h_last),
    .o_count(w_y), .o_last(w_v_last), .o_sync(w_vs), .o_active(w_v_act)
  );

  assign x           = w_x;
  assign y           = w_y;
  assign line_start  = (w_x == '0);
  assign frame_start = line_start && (w_y == '0);
  assign w_visible   = w_h_act && w_v_act;

  // The first pixel of a frame already uses the mode being latched.
  assign w_mode = frame_start ? vga_mode_e'(mode) : r_mode;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_mode <= ModeBands;
    end else if (frame_start) begin
      r_mode <= vga_mode_e'(mode);
    end
  end

  // Band and bar position tracked incrementally so no divider is needed.
  always_ff @(posedge vga_clock) begin
    if (reset || w_h_last) begin
      r_band     <= '0;
      r_band_sub <= '0;
      r_bar      <= '0;
      r_bar_sub  <= '0;
    end else begin
      if (r_band_sub == BandSubLast) begin
        r_band_sub <= '0;
        if (r_band != BandLast) r_band <= r_band + 1'b1;
      end else begin
        r_band_sub <= r_band_sub + 1'b1;
      end
      if (r_bar_sub == BarSubLast) begin
        r_bar_sub <= '0;
        if (r_bar != BarBlack) r_bar <= r_bar + 1'b1;
      end else begin
        r_bar_sub <= r_bar_sub + 1'b1;
      end
    end
  end

  always_comb begin
    w_rgb = 3'b000;
    unique case (w_mode)
      ModeBands: begin
        for (int b = 0; b < BANDS; b++) begin
          if (r_band == BandW'(b)) w_rgb = {colour[3*b], colour[3*b+1], colour[3*b+2]};
        end
      end
      ModeBars:    w_rgb = bar_rgb(r_bar);
      ModeChecker: w_rgb = {3{w_x[CHK_LOG2] ^ w_y[CHK_LOG2]}};
      default:     w_rgb = 3'b000;
    endcase
    if (!w_visible) w_rgb = 3'b000;
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_hs1    <= ~HS_POL;
      r_vs1    <= ~VS_POL;
      r_blank1 <= 1'b0;
      r_rgb1   <= '0;
      r_hs2    <= ~HS_POL;
      r_vs2    <= ~VS_POL;
      r_blank2 <= 1'b0;
      r_rgb2   <= '0;
    end else begin
      r_hs1    <= w_hs;
      r_vs1    <= w_vs;
      r_blank1 <= w_visible;
      r_rgb1   <= w_rgb;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      r_blank2 <= r_blank1;
      r_rgb2   <= r_rgb1;
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (w_h_last && w_v_last) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign frame_count = r_frame_count;
  assign VGA_R       = {COLOUR_BITS{r_rgb2[2]}};
  assign VGA_G       = {COLOUR_BITS{r_rgb2[1]}};
  assign VGA_B       = {COLOUR_BITS{r_rgb2[0]}};
  assign VGA_HS      = r_hs2;
  assign VGA_VS      = r_vs2;
  assign VGA_BLANK   = r_blank2;
  assign VGA_SYNC    = 1'b1;
  assign VGA_CLK     = vga_clock;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: 640-wide main instance with a short 22-line frame, plus a 320-wide
// positive-HS instance running alongside on the same clock and reset.
module tb_vga_timing_controller;

  localparam int unsigned VA = 18, VF = 1, VSY = 2, VB = 1;
  localparam int FRAME = 800 * 22;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  colour;
  logic [1:0]  mode;
  logic [9:0]  x, y, s_x, s_y;
  logic        line_start, frame_start, s_line_start, s_frame_start;
  logic [15:0] frame_count, s_frame_count;
  logic [7:0]  VGA_R, VGA_G, VGA_B, s_r, s_g, s_b;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;
  logic        s_hs, s_vs, s_blank, s_sync, s_clk;
  logic [23:0] rgb;

  int checks = 0, failures = 0, n = 0;
  int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1;
  int vs_fall1 = -1, vs_fall2 = -1, vs_rise1 = -1;
  int shs_rise1 = -1, shs_rise2 = -1, shs_fall1 = -1;
  int hs_low = 0, vs_low = 0, blank_hi = 0;
  logic p_hs, p_vs, p_shs;

  always #5 clk = ~clk;
  assign rgb = {VGA_R, VGA_G, VGA_B};

  vga_timing_controller #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) u_dut (
    .vga_clock(clk), .reset(reset), .colour(colour), .mode(mode), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK)
  );

  vga_timing_controller #(
    .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24), .HS_POL(1'b1),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) u_dut_small (
    .vga_clock(clk), .reset(reset), .colour(colour), .mode(mode), .x(s_x), .y(s_y),
    .line_start(s_line_start), .frame_start(s_frame_start), .frame_count(s_frame_count),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK(s_blank), .VGA_SYNC(s_sync), .VGA_CLK(s_clk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic adv(input int target);
    while (n < target) step();
  endtask

  initial begin
    reset  = 1'b1;
    mode   = 2'd0;
    colour = 6'b100_001;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n     = 0;

    // First post-reset cycle: counters at origin, pipeline still cleared.
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_frame_start", frame_start, 1);
    chk("rst_line_start", line_start, 1);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_hs", VGA_HS, 1);
    chk("rst_vs", VGA_VS, 1);
    chk("rst_blank", VGA_BLANK, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_sync", VGA_SYNC, 1);
    chk("rst_small_hs", s_hs, 0);

    p_hs = VGA_HS; p_vs = VGA_VS; p_shs = s_hs;
    while (n < 2 * FRAME) begin
      step();
      if (p_hs && !VGA_HS) begin
        if (hs_fall1 < 0) hs_fall1 = n;
        else if (hs_fall2 < 0) hs_fall2 = n;
      end
      if (!p_hs && VGA_HS && hs_rise1 < 0) hs_rise1 = n;
      if (p_vs && !VGA_VS) begin
        if (vs_fall1 < 0) vs_fall1 = n;
        else if (vs_fall2 < 0) vs_fall2 = n;
      end
      if (!p_vs && VGA_VS && vs_rise1 < 0) vs_rise1 = n;
      if (!p_shs && s_hs) begin
        if (shs_rise1 < 0) shs_rise1 = n;
        else if (shs_rise2 < 0) shs_rise2 = n;
      end
      if (p_shs && !s_hs && shs_fall1 < 0) shs_fall1 = n;
      if (!VGA_HS) hs_low++;
      if (!VGA_VS) vs_low++;
      if (VGA_BLANK) blank_hi++;
      p_hs = VGA_HS; p_vs = VGA_VS; p_shs = s_hs;

      // Outputs at cycle n belong to raster position n-2.
      case (n)
        1:     chk("pos_m1_blank", VGA_BLANK, 0);
        2:     chk("band0_x0", rgb, 24'hFF0000);
        65:    chk("band0_x63", rgb, 24'hFF0000);
        66:    chk("band1_x64", rgb, 24'h0000FF);
        641: begin
          chk("band1_x639", rgb, 24'h0000FF);
          chk("blank_x639", VGA_BLANK, 1);
        end
        642: begin
          chk("x640_black", rgb, 24'h000000);
          chk("blank_x640", VGA_BLANK, 0);
        end
        800: begin
          chk("line1_x", x, 0);
          chk("line1_y", y, 1);
          chk("line1_line_start", line_start, 1);
          chk("line1_frame_start", frame_start, 0);
        end
        801:   chk("line1_x1_line_start", line_start, 0);
        8000:  mode = 2'd2;
        8818:  chk("midframe_mode_ignored", rgb, 24'hFF0000);
        17599: chk("fc_before_wrap", frame_count, 0);
        17600: begin
          chk("fc_after_frame1", frame_count, 1);
          chk("frame1_frame_start", frame_start, 1);
        end
        17618: chk("chk_x16_y0_white", rgb, 24'hFFFFFF);
        30418: chk("chk_x16_y16_black", rgb, 24'h000000);
        31000: mode = 2'd1;
        default: ;
      endcase
    end

    chk("hs_first_fall", hs_fall1, 658);
    chk("hs_first_rise", hs_rise1, 754);
    chk("hs_period", hs_fall2 - hs_fall1, 800);
    chk("hs_low_cycles", hs_low, 44 * 96);
    chk("vs_first_fall", vs_fall1, 19 * 800 + 2);
    chk("vs_first_rise", vs_rise1, 21 * 800 + 2);
    chk("vs_period", vs_fall2 - vs_fall1, FRAME);
    chk("vs_low_cycles", vs_low, 4 * 800);
    chk("blank_hi_cycles", blank_hi, 2 * 18 * 640);
    chk("small_hs_rise", shs_rise1, 330);
    chk("small_hs_fall", shs_fall1, 378);
    chk("small_hs_period", shs_rise2 - shs_rise1, 400);
    chk("fc_two_frames", frame_count, 2);
    chk("frame2_x", x, 0);
    chk("frame2_y", y, 0);

    // Frame 2 latched colour bars.
    adv(2 * FRAME + 82);
    chk("bar_x80_yellow", rgb, 24'hFFFF00);
    adv(2 * FRAME + 561);
    chk("bar_x559_blue", rgb, 24'h0000FF);
    adv(2 * FRAME + 562);
    chk("bar_x560_black", rgb, 24'h000000);

    // Mid-line reset.
    adv(2 * FRAME + 5 * 800 + 300);
    chk("pre_reset_x", x, 300);
    chk("pre_reset_y", y, 5);
    reset = 1'b1;
    mode  = 2'd0;
    step();
    reset = 1'b0;
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_fc", frame_count, 0);
    chk("mid_rst_blank0", VGA_BLANK, 0);
    chk("mid_rst_rgb0", rgb, 0);
    chk("mid_rst_hs0", VGA_HS, 1);
    step();
    chk("mid_rst_blank1", VGA_BLANK, 0);
    chk("mid_rst_rgb1", rgb, 0);
    chk("mid_rst_x1", x, 1);
    step();
    chk("mid_rst_blank2", VGA_BLANK, 1);
    chk("mid_rst_rgb2", rgb, 24'hFF0000);
    chk("mid_rst_fc2", frame_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Parametrised 2nd-generation VGA raster controller: generates horizontal/vertical counters, sync and blank for any timing set, and drives replicated RGB from either per-band external colour bits or an internal test pattern. Sits between the pixel-source logic (which reads `x`/`y` and supplies `colour`) and the DAC pins. Adds programmable porches and sync polarity, N colour bands, mode-switched test patterns, frame/line markers and synchronous reset.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, active level of HS / VS
- XW, 10, counter width; H_TOTAL and V_TOTAL ≤ 2**XW
- COLOUR_BITS, 8, bits per output channel
- BANDS, 2, vertical colour bands (≥1)
- BAND_WIDTH, 64, pixels per band (last band extends to line end)
- CHK_LOG2, 4, log2 of checkerboard square size
---
- vga_clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- colour  in  3*BANDS  band b: bit 3b=R, 3b+1=G, 3b+2=B
- mode  in  2  0 bands, 1 colour bars, 2 checkerboard, 3 black
- x / y  out  XW  current counter values
- line_start  out  1  high while x==0
- frame_start  out  1  high while x==0 && y==0
- frame_count  out  16  completed frames, wraps
- VGA_R / VGA_G / VGA_B  out  COLOUR_BITS  pixel data
- VGA_HS / VGA_VS  out  1  sync
- VGA_BLANK  out  1  high in visible region
- VGA_SYNC  out  1  constant 1
- VGA_CLK  out  1  vga_clock passthrough

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- x counts 0..H_TOTAL-1, wraps to 0; y increments on x wrap, wraps to 0 when x and y both at last value.
- HS active (=HS_POL) for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); VS for y in [V_ACTIVE+V_FP, +V_SYNC-1] (490..491).
- Visible: x<H_ACTIVE && y<V_ACTIVE.
- Active mode latched only in the cycle frame_start is high; mid-frame mode changes ignored until next frame. Reset latches mode=0.
- Mode 0: band = min(x/BAND_WIDTH, BANDS-1), tracked by a band counter/sub-counter cleared at x==0 (no divider). x<BAND_WIDTH → band 0; x==BAND_WIDTH → band 1.
- Mode 1: 8 bars of H_ACTIVE/8 px, order white, yellow, cyan, green, magenta, red, blue, black (RGB 111,110,011,010,101,100,001,000); remainder pixels stay black.
- Mode 2: white when x[CHK_LOG2]^y[CHK_LOG2]=1 else black. Mode 3: black.
- Each 1-bit R/G/B replicated to COLOUR_BITS. RGB forced to 0 whenever pixel not visible.
- frame_count increments on the (last x, last y)→(0,0) wrap.

## Timing
- x, y, line_start, frame_start, mode-latch: combinationally from counter state, same cycle.
- colour sampled in the same cycle as the x/y it belongs to.
- HS, VS, BLANK, RGB: exactly 2-cycle latency from x/y, all mutually aligned.
- Reset (any cycle, incl. mid-line): next edge x=0, y=0, frame_count=0; pipeline cleared: HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0 for 2 cycles, then normal output of (0,0) onward. frame_start high in first post-reset cycle; no frame_count increment for that.
- frame_count 16'hFFFF wraps to 0.

## Structure
- Package vga_timing_pkg: default 640×480 timing constants, mode encodings, 8-entry bar colour table.
- Sub-module vga_axis_counter (instanced for H and V): counter with wrap, enable, sync and active decode from ACTIVE/FP/SYNC/BP parameters.

## Test plan
- Reset then free-run 2 frames → HS low exactly cycles x=656..751 (delayed 2), period 800; VS low on lines 490–491, period 420000 cycles; frame_count=2.
- mode=0, BANDS=2, colour=6'b100_001 → x=0..63 VGA_R=8'hFF, G=B=0; x=64..639 VGA_B=8'hFF only; x≥640 all 0.
- mode=1 → x=80 yellow (R=G=FF,B=0); x=559 blue; x=560 black.
- mode 0→2 asserted at y=100 → pattern unchanged until next frame_start; then x=16,y=0 white, x=16,y=16 black.
- reset asserted at x=300,y=200 → x=y=0 next cycle, BLANK=0 and RGB=0 for 2 cycles, frame_count=0.
- H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24, HS_POL=1 → HS high x=328..375, line period 400.
